// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state enum, opcode constants, ALU class codes and datapath mux selects.
package mips_ctrl_pkg;

    // Encodings follow the order the states are listed in the control table.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // FETCH mux settings with every write strobe held off; driven during reset.
    function automatic ctrl_t fetch_idle_ctrl();
        ctrl_t c;
        c           = '0;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PC_ALU;
        return c;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decoder: maps the current state (plus the mem_ready and zero
// qualifiers) onto the datapath control bus.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]        state,
    input  logic              mem_ready,
    input  logic              zero,
    output logic [CTRL_W-1:0] ctrl
);

    ctrl_t w_c;

    always_comb begin
        w_c = '0;
        case (state)
            ST_FETCH: begin
                w_c.mem_read  = 1'b1;
                w_c.alu_src_b = SRCB_FOUR;
                w_c.alu_op    = ALU_ADD;
                w_c.pc_src    = PC_ALU;
                // IR and PC only load once the instruction word has arrived.
                w_c.ir_write  = mem_ready;
                w_c.pc_en     = mem_ready;
            end
            ST_DECODE: begin
                w_c.alu_src_b = SRCB_BROFF;
                w_c.alu_op    = ALU_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_IMM;
                w_c.alu_op    = ALU_ADD;
            end
            ST_MEMRD: begin
                w_c.mem_read = 1'b1;
                w_c.iord     = 1'b1;
            end
            ST_MEMWB: begin
                w_c.mem_to_reg = 1'b1;
                w_c.reg_write  = 1'b1;
            end
            ST_MEMWR: begin
                w_c.mem_write = 1'b1;
                w_c.iord      = 1'b1;
            end
            ST_EXEC: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_REG;
                w_c.alu_op    = ALU_FUNCT;
            end
            ST_ALUWB: begin
                w_c.reg_dst   = 1'b1;
                w_c.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = SRCB_REG;
                w_c.alu_op    = ALU_SUB;
                w_c.pc_src    = PC_ALUOUT;
                w_c.pc_en     = zero;
            end
            ST_ADDIWB: begin
                w_c.reg_write = 1'b1;
            end
            ST_JUMP: begin
                w_c.pc_src = PC_JUMP;
                w_c.pc_en  = 1'b1;
            end
            default: w_c = '0;
        endcase
    end

    assign ctrl = w_c;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: state register and next-state logic, with
// output decoding delegated to mc_ctrl_decode and gated by reset.
module mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_to_reg,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [1:0]     alu_op,
    output logic [1:0]     pc_src,
    output logic           pc_en,
    output logic           illegal,
    output logic [3:0]     state
);

    state_t            r_state;
    state_t            w_state_next;
    logic              w_illegal;
    logic [CTRL_W-1:0] w_dec_bus;
    ctrl_t             w_dec;
    ctrl_t             w_out;
    logic              w_illegal_out;
    logic [3:0]        w_state_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_FETCH;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH:  w_state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) begin
                    w_state_next = ST_MEMADR;
                end else if (opcode == OPW'(OP_RTYPE)) begin
                    w_state_next = ST_EXEC;
                end else if (opcode == OPW'(OP_BEQ)) begin
                    w_state_next = ST_BRANCH;
                end else if (opcode == OPW'(OP_ADDI)) begin
                    w_state_next = ST_ADDIEX;
                end else if (opcode == OPW'(OP_J)) begin
                    w_state_next = ST_JUMP;
                end else begin
                    w_state_next = ST_FETCH;
                    w_illegal    = 1'b1;
                end
            end
            // Opcode is re-checked here; anything but LW/SW aborts to FETCH.
            ST_MEMADR: begin
                if (opcode == OPW'(OP_LW)) begin
                    w_state_next = ST_MEMRD;
                end else if (opcode == OPW'(OP_SW)) begin
                    w_state_next = ST_MEMWR;
                end else begin
                    w_state_next = ST_FETCH;
                    w_illegal    = 1'b1;
                end
            end
            ST_MEMRD:  w_state_next = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  w_state_next = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_state_next = ST_ALUWB;
            ST_ADDIEX: w_state_next = ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_ADDIWB, ST_JUMP:
                       w_state_next = ST_FETCH;
            default: begin
                w_state_next = ST_FETCH;
                w_illegal    = 1'b1;
            end
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (r_state),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (w_dec_bus)
    );

    assign w_dec = ctrl_t'(w_dec_bus);

    // Reset overrides the decoded bus so nothing is written while rst_n is low.
    always_comb begin
        w_out         = w_dec;
        w_illegal_out = w_illegal;
        w_state_out   = r_state;
        if (!rst_n) begin
            w_out         = fetch_idle_ctrl();
            w_illegal_out = 1'b0;
            w_state_out   = ST_FETCH;
        end
    end

    assign iord       = w_out.iord;
    assign mem_read   = w_out.mem_read;
    assign mem_write  = w_out.mem_write;
    assign ir_write   = w_out.ir_write;
    assign reg_write  = w_out.reg_write;
    assign reg_dst    = w_out.reg_dst;
    assign mem_to_reg = w_out.mem_to_reg;
    assign alu_src_a  = w_out.alu_src_a;
    assign alu_src_b  = w_out.alu_src_b;
    assign alu_op     = w_out.alu_op;
    assign pc_src     = w_out.pc_src;
    assign pc_en      = w_out.pc_en;
    assign illegal    = w_illegal_out;
    assign state      = w_state_out;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: instruction-level model produces the expected
// per-cycle control vector; a negedge monitor pops and compares it.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       iord, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, pc_en, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    always #5 clk = ~clk;

    mc_control #(.OPW(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .illegal    (illegal),
        .state      (state)
    );

    logic [19:0] act;
    assign act = {state, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal};

    // Instruction phases as the bench sees them (one per clock cycle).
    localparam int P_RST = 0, P_FETCH = 1, P_DECODE = 2, P_DECILL = 3, P_MEMADR = 4,
                   P_MEMRD = 5, P_MEMWB = 6, P_MEMWR = 7, P_EXEC = 8, P_ALUWB = 9,
                   P_BRANCH = 10, P_ADDIEX = 11, P_ADDIWB = 12, P_JUMP = 13;

    localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    typedef struct {
        logic [19:0] v;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;

    // Control table written directly from the state descriptions.
    function automatic logic [19:0] model(int p, logic mr, logic z);
        logic [3:0] st;
        logic       io, mrd, mwr, irw, rw, rd, m2r, sa, pe, il;
        logic [1:0] sb, op, ps;
        {st, io, mrd, mwr, irw, rw, rd, m2r, sa, pe, il} = '0;
        {sb, op, ps} = '0;
        case (p)
            P_RST:    begin st = 4'd0;  mrd = 1'b1; sb = 2'b01; end
            P_FETCH:  begin st = 4'd0;  mrd = 1'b1; sb = 2'b01; irw = mr; pe = mr; end
            P_DECODE: begin st = 4'd1;  sb = 2'b11; end
            P_DECILL: begin st = 4'd1;  sb = 2'b11; il = 1'b1; end
            P_MEMADR: begin st = 4'd2;  sa = 1'b1; sb = 2'b10; end
            P_MEMRD:  begin st = 4'd3;  mrd = 1'b1; io = 1'b1; end
            P_MEMWB:  begin st = 4'd4;  m2r = 1'b1; rw = 1'b1; end
            P_MEMWR:  begin st = 4'd5;  mwr = 1'b1; io = 1'b1; end
            P_EXEC:   begin st = 4'd6;  sa = 1'b1; op = 2'b10; end
            P_ALUWB:  begin st = 4'd7;  rd = 1'b1; rw = 1'b1; end
            P_BRANCH: begin st = 4'd8;  sa = 1'b1; op = 2'b01; ps = 2'b01; pe = z; end
            P_ADDIEX: begin st = 4'd9;  sa = 1'b1; sb = 2'b10; end
            P_ADDIWB: begin st = 4'd10; rw = 1'b1; end
            P_JUMP:   begin st = 4'd11; ps = 2'b10; pe = 1'b1; end
            default:  st = 4'hf;
        endcase
        return {st, io, mrd, mwr, irw, rw, rd, m2r, sa, sb, op, ps, pe, il};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    // One clock cycle: drive inputs, queue the expected vector, advance.
    task automatic cyc(int p, logic [5:0] opc, logic mr, logic z, logic rn, string tag);
        exp_t e;
        rst_n     = rn;
        opcode    = opc;
        mem_ready = mr;
        zero      = z;
        e.v       = model(p, mr, z);
        e.tag     = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(logic [5:0] opc, int fst, int mst, logic bz, string tag);
        for (int i = 0; i < fst; i++) cyc(P_FETCH, rop(), 1'b0, rb(), 1'b1, tag);
        cyc(P_FETCH, rop(), 1'b1, rb(), 1'b1, tag);
        case (opc)
            LW: begin
                cyc(P_DECODE, opc, rb(), rb(), 1'b1, tag);
                cyc(P_MEMADR, opc, rb(), rb(), 1'b1, tag);
                for (int i = 0; i < mst; i++) cyc(P_MEMRD, rop(), 1'b0, rb(), 1'b1, tag);
                cyc(P_MEMRD, rop(), 1'b1, rb(), 1'b1, tag);
                cyc(P_MEMWB, rop(), rb(), rb(), 1'b1, tag);
            end
            SW: begin
                cyc(P_DECODE, opc, rb(), rb(), 1'b1, tag);
                cyc(P_MEMADR, opc, rb(), rb(), 1'b1, tag);
                for (int i = 0; i < mst; i++) cyc(P_MEMWR, rop(), 1'b0, rb(), 1'b1, tag);
                cyc(P_MEMWR, rop(), 1'b1, rb(), 1'b1, tag);
            end
            RTYPE: begin
                cyc(P_DECODE, opc, rb(), rb(), 1'b1, tag);
                cyc(P_EXEC, rop(), rb(), rb(), 1'b1, tag);
                cyc(P_ALUWB, rop(), rb(), rb(), 1'b1, tag);
            end
            ADDI: begin
                cyc(P_DECODE, opc, rb(), rb(), 1'b1, tag);
                cyc(P_ADDIEX, rop(), rb(), rb(), 1'b1, tag);
                cyc(P_ADDIWB, rop(), rb(), rb(), 1'b1, tag);
            end
            BEQ: begin
                cyc(P_DECODE, opc, rb(), rb(), 1'b1, tag);
                cyc(P_BRANCH, rop(), rb(), bz, 1'b1, tag);
            end
            JMP: begin
                cyc(P_DECODE, opc, rb(), rb(), 1'b1, tag);
                cyc(P_JUMP, rop(), rb(), rb(), 1'b1, tag);
            end
            default: cyc(P_DECILL, opc, rb(), rb(), 1'b1, tag);
        endcase
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            if (act !== mon_e.v) begin
                bad++;
                $display("FAIL %s cyc=%0d: got %05h required %05h", mon_e.tag, ncyc, act, mon_e.v);
            end else begin
                $display("ok   %s cyc=%0d: vec %05h", mon_e.tag, ncyc, act);
            end
        end
    end

    initial begin
        logic [5:0] opc;
        logic [5:0] legal_ops [6];
        legal_ops = '{RTYPE, LW, SW, BEQ, ADDI, JMP};
        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; zero = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cyc(P_RST, rop(), rb(), rb(), 1'b0, "reset");

        run_instr(LW, 0, 0, 1'b0, "lw");
        run_instr(SW, 0, 3, 1'b0, "sw_stall");
        run_instr(BEQ, 0, 0, 1'b1, "beq_taken");
        run_instr(BEQ, 0, 0, 1'b0, "beq_not");
        run_instr(6'b111111, 0, 0, 1'b0, "illegal");
        run_instr(RTYPE, 0, 0, 1'b0, "rtype");
        run_instr(ADDI, 0, 0, 1'b0, "addi");
        run_instr(LW, 2, 2, 1'b0, "lw_stall");

        // Reset asserted while a load is stalled in MEMRD, then a jump.
        cyc(P_FETCH, rop(), 1'b1, rb(), 1'b1, "rst_mid");
        cyc(P_DECODE, LW, rb(), rb(), 1'b1, "rst_mid");
        cyc(P_MEMADR, LW, rb(), rb(), 1'b1, "rst_mid");
        cyc(P_MEMRD, rop(), 1'b0, rb(), 1'b1, "rst_mid");
        cyc(P_MEMRD, rop(), 1'b0, rb(), 1'b1, "rst_mid");
        cyc(P_RST, rop(), 1'b0, rb(), 1'b0, "rst_mid");
        run_instr(JMP, 0, 0, 1'b0, "jump_after_rst");

        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = int'($urandom_range(0, 6));
            opc = (sel < 6) ? legal_ops[sel] : rop();
            if ($urandom_range(0, 19) == 0) cyc(P_RST, rop(), rb(), rb(), 1'b0, "rnd_rst");
            run_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb(), "rnd");
        end

        repeat (2) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: OPW, 6, opcode field width in bits.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 Port: clk  input  1  rising-edge clock, sole clock domain.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: opcode  input  OPW  instruction[31:26] from the IR register.
REQ-006 Port: zero  input  1  ALU zero flag.
REQ-007 Port: mem_ready  input  1  memory access completes this cycle.
REQ-008 Port: iord  output  1  address mux select (0=PC, 1=ALUOut).
REQ-009 Port: mem_read, mem_write, ir_write, reg_write  output  1 each  strobes.
REQ-010 Port: reg_dst, mem_to_reg, alu_src_a  output  1 each  mux2 selects.
REQ-011 Port: alu_src_b, alu_op, pc_src  output  2 each  mux4 selects / ALU class.
REQ-012 Port: pc_en  output  1  PC register write enable.
REQ-013 Port: illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-014 Port: state  output  4  current state encoding, for debug.

Function
REQ-015 The block SHALL be a Moore FSM; all outputs are decoded from state, except the mem_ready, zero and opcode qualifiers listed below.
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-017 Opcodes: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
REQ-018 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_en=mem_ready; next state DECODE if mem_ready, else FETCH.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP; any other opcode->FETCH with illegal=1 for that cycle.
REQ-020 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: LW->MEMRD, SW->MEMWR.
REQ-021 MEMRD: mem_read=1, iord=1. Next state MEMWB when mem_ready, else hold in MEMRD.
REQ-022 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
REQ-023 MEMWR: mem_write=1, iord=1 (held high while waiting). Next state FETCH when mem_ready, else hold.
REQ-024 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
REQ-025 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state FETCH.
REQ-027 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
REQ-028 ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state FETCH.
REQ-029 JUMP: pc_src=10, pc_en=1. Next state FETCH.
REQ-030 Any output not listed for a state SHALL be 0.
REQ-031 Latency with mem_ready tied to 1, in cycles: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3; each memory stall adds 1 cycle per stalled cycle.
REQ-032 The opcode input SHALL be sampled only in DECODE and MEMADR.
REQ-033 mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.
REQ-034 Unused state encodings SHALL transition to FETCH with illegal=1.

Reset
REQ-035 When rst_n=0 at a rising edge, state SHALL become FETCH regardless of current state, including mid-stall.
REQ-036 While rst_n=0, mem_write, reg_write, ir_write, pc_en and illegal SHALL be forced to 0.
REQ-037 While rst_n=0, all other outputs SHALL take their FETCH values.

Structure
REQ-038 Package mips_ctrl_pkg SHALL hold the state enum, the opcode constants, the alu_op codes (00 add, 01 sub, 10 funct) and the alu_src_b/pc_src select codes.
REQ-039 Output decoding SHALL be a combinational sub-module, mc_ctrl_decode (inputs: state, mem_ready, zero; outputs: the control bus).
REQ-040 The state register and next-state logic SHALL reside in mc_control.

Verification
REQ-041 Reset, then opcode=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; reg_write=1 only in cycle 5, with mem_to_reg=1.
REQ-042 Opcode=101011 with mem_ready=0 for 3 cycles in MEMWR -> mem_write and iord held at 1 for 4 cycles; FETCH follows.
REQ-043 Opcode=000100: zero=1 -> pc_en=1 and pc_src=01 in BRANCH; zero=0 -> pc_en=0; return to FETCH on cycle 4.
REQ-044 Opcode=111111 -> illegal=1 for exactly one cycle in DECODE, next state FETCH, no write strobe asserted.
REQ-045 rst_n=0 while in MEMRD stall -> next state FETCH and all write strobes 0; after release, the FETCH sequence for opcode=000010 reaches JUMP with pc_src=10, pc_en=1.
REQ-046 Back-to-back RTYPE then ADDI -> ALUWB with reg_dst=1 at cycle 4, ADDIWB with reg_dst=0 at cycle 8.
